// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel-rate divider, h/v counters, zero-skew sync/active, line/frame pulses.
// Optional VGA_GAME_TICK_EN adds frame-derived game-rate ticks on game_tick.
module vga_timing_gen #(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter int unsigned SYNC_POL = 0,
  parameter int unsigned CW       = 10
) (
  input  logic          i_clk,
  input  logic          rst,
  output logic [CW-1:0] hcount,
  output logic [CW-1:0] vcount,
  output logic          hs,
  output logic          vs,
  output logic          active,
  output logic          pix_en,
  output logic          line_start,
  output logic          frame_start,
  output logic [7:0]    frame_cnt,
  output logic [2:0]    game_tick
);

  localparam int unsigned DW       = 4;
  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC - 1;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC - 1;
  localparam logic        POL      = 1'(SYNC_POL);

  logic [DW-1:0] div_q, div_d;
  logic [CW-1:0] hcount_q, hcount_d;
  logic [CW-1:0] vcount_q, vcount_d;
  logic          hs_q, hs_d;
  logic          vs_q, vs_d;
  logic          active_q, active_d;
  logic          pix_en_q, pix_en_d;
  logic          line_start_q, line_start_d;
  logic          frame_start_q, frame_start_d;
  logic [7:0]    frame_cnt_q, frame_cnt_d;

  // Counters step on the edge that closes a pix_en cycle; decodes use the next-state values.
  always_comb begin
    div_d         = (div_q == DW'(CLK_DIV - 1)) ? '0 : div_q + DW'(1);
    pix_en_d      = (div_d == DW'(CLK_DIV - 1));
    hcount_d      = hcount_q;
    vcount_d      = vcount_q;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    frame_cnt_d   = frame_cnt_q;
    if (pix_en_q) begin
      if (hcount_q == CW'(H_TOTAL - 1)) begin
        hcount_d     = '0;
        line_start_d = 1'b1;
        if (vcount_q == CW'(V_TOTAL - 1)) begin
          vcount_d      = '0;
          frame_start_d = 1'b1;
          frame_cnt_d   = frame_cnt_q + 8'd1;
        end else begin
          vcount_d = vcount_q + CW'(1);
        end
      end else begin
        hcount_d = hcount_q + CW'(1);
      end
    end
    hs_d     = (32'(hcount_d) >= HS_START && 32'(hcount_d) <= HS_END) ? POL : ~POL;
    vs_d     = (32'(vcount_d) >= VS_START && 32'(vcount_d) <= VS_END) ? POL : ~POL;
    active_d = (32'(hcount_d) < H_ACTIVE) && (32'(vcount_d) < V_ACTIVE);
  end

  always_ff @(posedge i_clk or posedge rst) begin
    if (rst) begin
      div_q         <= '0;
      hcount_q      <= '0;
      vcount_q      <= '0;
      hs_q          <= ~POL;
      vs_q          <= ~POL;
      active_q      <= 1'b1;
      pix_en_q      <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_cnt_q   <= '0;
    end else begin
      div_q         <= div_d;
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      active_q      <= active_d;
      pix_en_q      <= pix_en_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

  assign hcount      = hcount_q;
  assign vcount      = vcount_q;
  assign hs          = hs_q;
  assign vs          = vs_q;
  assign active      = active_q;
  assign pix_en      = pix_en_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign frame_cnt   = frame_cnt_q;

`ifdef VGA_GAME_TICK_EN
  logic [2:0] game_tick_q, game_tick_d;

  // Tick k fires with frame_start when the new frame count is a multiple of 2^(k+1).
  always_comb begin
    game_tick_d = {frame_start_d && (frame_cnt_d[2:0] == 3'd0),
                   frame_start_d && (frame_cnt_d[1:0] == 2'd0),
                   frame_start_d && !frame_cnt_d[0]};
  end

  always_ff @(posedge i_clk or posedge rst) begin
    if (rst) begin
      game_tick_q <= '0;
    end else begin
      game_tick_q <= game_tick_d;
    end
  end

  assign game_tick = game_tick_q;
`else
  assign game_tick = '0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three configurations checked every cycle against an arithmetic
// raster model (pixel index derived from i_clk edges since reset release), with random async resets.
module tb_vga_timing_gen;

  typedef struct {
    int d; int ha; int hf; int hs; int hb; int va; int vf; int vs; int vb; int pol;
  } cfg_t;

  typedef struct {
    int h; int v; int hs; int vs; int act; int pe; int ls; int fs; int fc; int gt;
  } exp_t;

  localparam cfg_t C0 = '{4, 640, 16, 96, 48, 480, 10, 2, 33, 0};
  localparam cfg_t C1 = '{1, 8, 2, 2, 2, 4, 1, 1, 1, 1};
  localparam cfg_t C2 = '{3, 10, 3, 4, 2, 5, 2, 2, 1, 0};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0 = 1'b1, rst1 = 1'b1, rst2 = 1'b1;

  logic [9:0] h0, v0;
  logic [3:0] h1, v1;
  logic [4:0] h2, v2;
  logic       hs0, vs0, act0, pe0, ls0, fs0;
  logic       hs1, vs1, act1, pe1, ls1, fs1;
  logic       hs2, vs2, act2, pe2, ls2, fs2;
  logic [7:0] fc0, fc1, fc2;
  logic [2:0] gt0, gt1, gt2;

  vga_timing_gen u_dut0 (
    .i_clk(clk), .rst(rst0), .hcount(h0), .vcount(v0), .hs(hs0), .vs(vs0), .active(act0),
    .pix_en(pe0), .line_start(ls0), .frame_start(fs0), .frame_cnt(fc0), .game_tick(gt0));

  vga_timing_gen #(.CLK_DIV(1), .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
                   .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .SYNC_POL(1), .CW(4)) u_dut1 (
    .i_clk(clk), .rst(rst1), .hcount(h1), .vcount(v1), .hs(hs1), .vs(vs1), .active(act1),
    .pix_en(pe1), .line_start(ls1), .frame_start(fs1), .frame_cnt(fc1), .game_tick(gt1));

  vga_timing_gen #(.CLK_DIV(3), .H_ACTIVE(10), .H_FP(3), .H_SYNC(4), .H_BP(2),
                   .V_ACTIVE(5), .V_FP(2), .V_SYNC(2), .V_BP(1), .SYNC_POL(0), .CW(5)) u_dut2 (
    .i_clk(clk), .rst(rst2), .hcount(h2), .vcount(v2), .hs(hs2), .vs(vs2), .active(act2),
    .pix_en(pe2), .line_start(ls2), .frame_start(fs2), .frame_cnt(fc2), .game_tick(gt2));

  // i_clk edges seen since each reset release
  int n0 = 0, n1 = 0, n2 = 0;
  always @(posedge clk or posedge rst0) if (rst0) n0 <= 0; else n0 <= n0 + 1;
  always @(posedge clk or posedge rst1) if (rst1) n1 <= 0; else n1 <= n1 + 1;
  always @(posedge clk or posedge rst2) if (rst2) n2 <= 0; else n2 <= n2 + 1;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int last_ev[3] = '{-1, -1, -1};
  int nfs1   = 0;

  // Pixel steps completed after n edges: a step lands on each edge that closes a pix_en cycle.
  function automatic int steps(int n, int d);
    if (n <= 1) return 0;
    return (n / d) - ((d == 1) ? 1 : 0);
  endfunction

  function automatic exp_t model(cfg_t c, int n);
    exp_t e;
    int ht, vt, p, line, frame;
    bit stepped;
    ht      = c.ha + c.hf + c.hs + c.hb;
    vt      = c.va + c.vf + c.vs + c.vb;
    p       = steps(n, c.d);
    line    = p / ht;
    frame   = line / vt;
    e.h     = p % ht;
    e.v     = line % vt;
    e.fc    = frame % 256;
    stepped = (n >= 1) && (steps(n, c.d) != steps(n - 1, c.d));
    e.pe    = ((n >= 1) && (n % c.d == c.d - 1)) ? 1 : 0;
    e.ls    = (stepped && e.h == 0) ? 1 : 0;
    e.fs    = (e.ls == 1 && e.v == 0) ? 1 : 0;
    e.hs    = (e.h >= c.ha + c.hf && e.h < c.ha + c.hf + c.hs) ? c.pol : 1 - c.pol;
    e.vs    = (e.v >= c.va + c.vf && e.v < c.va + c.vf + c.vs) ? c.pol : 1 - c.pol;
    e.act   = (e.h < c.ha && e.v < c.va) ? 1 : 0;
`ifdef VGA_GAME_TICK_EN
    e.gt    = ((e.fs == 1 && e.fc % 2 == 0) ? 1 : 0) + ((e.fs == 1 && e.fc % 4 == 0) ? 2 : 0)
            + ((e.fs == 1 && e.fc % 8 == 0) ? 4 : 0);
`else
    e.gt    = 0;
`endif
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  task automatic chk_dut(input string nm, input cfg_t c, input int n,
                         input logic [31:0] h, input logic [31:0] v,
                         input logic hs, input logic vs, input logic act, input logic pe,
                         input logic ls, input logic fs, input logic [7:0] fc, input logic [2:0] gt);
    exp_t e;
    e = model(c, n);
    chk({nm, ".hcount"}, h, 32'(e.h));
    chk({nm, ".vcount"}, v, 32'(e.v));
    chk({nm, ".hs"}, 32'(hs), 32'(e.hs));
    chk({nm, ".vs"}, 32'(vs), 32'(e.vs));
    chk({nm, ".active"}, 32'(act), 32'(e.act));
    chk({nm, ".pix_en"}, 32'(pe), 32'(e.pe));
    chk({nm, ".line_start"}, 32'(ls), 32'(e.ls));
    chk({nm, ".frame_start"}, 32'(fs), 32'(e.fs));
    chk({nm, ".frame_cnt"}, 32'(fc), 32'(e.fc));
    chk({nm, ".game_tick"}, 32'(gt), 32'(e.gt));
  endtask

  task automatic check_now(input int which);
    case (which)
      0: chk_dut("d0", C0, n0, 32'(h0), 32'(v0), hs0, vs0, act0, pe0, ls0, fs0, fc0, gt0);
      1: chk_dut("d1", C1, n1, 32'(h1), 32'(v1), hs1, vs1, act1, pe1, ls1, fs1, fc1, gt1);
      default: chk_dut("d2", C2, n2, 32'(h2), 32'(v2), hs2, vs2, act2, pe2, ls2, fs2, fc2, gt2);
    endcase
  endtask

  // Advance k cycles, checking the selected DUT mid-cycle plus its pulse periods.
  task automatic run(input int which, input int k);
    repeat (k) begin
      @(negedge clk);
      cyc++;
      check_now(which);
      case (which)
        0: if (ls0 === 1'b1) begin
             if (last_ev[0] >= 0) chk("d0.line_period", 32'(cyc - last_ev[0]), 32'd3200);
             last_ev[0] = cyc;
           end
        1: if (fs1 === 1'b1) begin
             if (last_ev[1] >= 0) chk("d1.frame_period", 32'(cyc - last_ev[1]), 32'd98);
             last_ev[1] = cyc;
             nfs1++;
             if (nfs1 == 256) chk("d1.frame_cnt_wrap", 32'(fc1), 32'd0);
           end
        default: if (fs2 === 1'b1) begin
             if (last_ev[2] >= 0) chk("d2.frame_period", 32'(cyc - last_ev[2]), 32'd570);
             last_ev[2] = cyc;
           end
      endcase
    end
  endtask

  task automatic set_rst(input int which, input logic val);
    case (which)
      0: rst0 = val;
      1: rst1 = val;
      default: rst2 = val;
    endcase
  endtask

  // Called at a negedge: raise reset mid-cycle, check before the next edge, hold, release.
  task automatic async_reset(input int which, input int hold);
    #1 set_rst(which, 1'b1);
    #1 check_now(which);
    run(which, hold);
    set_rst(which, 1'b0);
    last_ev[which] = -1;
    if (which == 1) nfs1 = 0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // default timing
    run(0, 3);
    rst0 = 1'b0;
    run(0, 3);
    run(0, 1);
    chk("d0.first_step", 32'(h0), 32'd1);
    run(0, int'($urandom_range(6500, 7500)));
    for (int i = 0; i < 4000 && h0 != 10'd300; i++) run(0, 1);
    chk("d0.reach_300", 32'(h0), 32'd300);
    async_reset(0, int'($urandom_range(1, 4)));
    run(0, 3);
    run(0, 1);
    chk("d0.restart_step", 32'(h0), 32'd1);
    run(0, 6500);
    rst0 = 1'b1;

    // small config, CLK_DIV 1, active-high sync, frame counter wrap
    run(1, 2);
    rst1 = 1'b0;
    run(1, int'($urandom_range(50, 300)));
    async_reset(1, int'($urandom_range(1, 3)));
    for (int i = 0; i < 26000 && nfs1 < 257; i++) run(1, 1);
    chk("d1.frames_seen", 32'(nfs1), 32'd257);
    rst1 = 1'b1;

    // divider 3, active-low sync, random reset points
    run(2, 2);
    rst2 = 1'b0;
    for (int r = 0; r < 3; r++) begin
      run(2, int'($urandom_range(200, 3000)));
      async_reset(2, int'($urandom_range(1, 5)));
    end
    run(2, 570 * 10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter CLK_DIV, default 4, i_clk cycles per pixel (100 MHz -> 25 MHz); legal range 1..16.
REQ-002 Parameters H_ACTIVE/H_FP/H_SYNC/H_BP, defaults 640/16/96/48, horizontal timing in pixels.
REQ-003 Parameters V_ACTIVE/V_FP/V_SYNC/V_BP, defaults 480/10/2/33, vertical timing in lines.
REQ-004 Parameter SYNC_POL, default 0, asserted level of hs/vs (0 = active-low).
REQ-005 Parameter CW, default 10, counter width; H_TOTAL and V_TOTAL SHALL each be <= 2^CW; H_SYNC, V_SYNC >= 1.
REQ-006 i_clk  in  1  sole clock; all logic SHALL be on its rising edge.
REQ-007 rst  in  1  asynchronous, active-high reset.
REQ-008 hcount  out  CW  current pixel column, 0..H_TOTAL-1.
REQ-009 vcount  out  CW  current line, 0..V_TOTAL-1.
REQ-010 hs / vs  out  1 each  horizontal / vertical sync at SYNC_POL level.
REQ-011 active  out  1  high when hcount < H_ACTIVE and vcount < V_ACTIVE.
REQ-012 pix_en  out  1  one-i_clk pulse marking each pixel step.
REQ-013 line_start / frame_start  out  1 each  one-i_clk pulses.
REQ-014 frame_cnt  out  8  free-running frame counter.
REQ-015 game_tick  out  3  frame-derived game-rate pulses (see Configuration).

Function
REQ-016 Divider SHALL count 0..CLK_DIV-1 and wrap; pix_en SHALL be high exactly in cycles where divider = CLK_DIV-1; CLK_DIV = 1 -> pix_en constantly high.
REQ-017 On pix_en, hcount SHALL increment; at H_TOTAL-1 it SHALL wrap to 0 and vcount SHALL increment in the same cycle.
REQ-018 vcount at V_TOTAL-1 with hcount wrap SHALL wrap to 0.
REQ-019 Counters SHALL hold when pix_en is low.
REQ-020 hs, vs, active SHALL be registered, computed from next-state counters, so they align with hcount/vcount in the same cycle (zero skew).
REQ-021 hs SHALL equal SYNC_POL iff H_ACTIVE+H_FP <= hcount <= H_ACTIVE+H_FP+H_SYNC-1, else ~SYNC_POL; vs likewise with vertical parameters on vcount.
REQ-022 line_start SHALL pulse for one i_clk in the cycle hcount becomes 0; frame_start additionally requires vcount becoming 0.
REQ-023 frame_cnt SHALL increment on each frame_start, wrapping 255 -> 0.

Reset
REQ-024 While rst high: divider 0, hcount 0, vcount 0, hs = vs = ~SYNC_POL, active 1, pix_en 0, line_start 0, frame_start 0, frame_cnt 0, game_tick 0.
REQ-025 Reset mid-frame SHALL take effect immediately without waiting for i_clk; no pulse SHALL be emitted during reset.
REQ-026 After release the first pix_en SHALL occur CLK_DIV cycles later; the first hcount 0 -> 1 step occurs on it; no line_start/frame_start SHALL be issued for the reset-entered position.

Configuration
REQ-027 Macro VGA_GAME_TICK_EN defined: game_tick[k] (k = 0..2) SHALL pulse coincident with frame_start when the new frame_cnt has its low k+1 bits all zero (every 2, 4, 8 frames).
REQ-028 Macro VGA_GAME_TICK_EN undefined: game_tick SHALL be tied to 0, port retained, no tick logic synthesised.

Verification
REQ-029 Defaults: after reset release, hcount steps every 4 i_clk; 799 -> 0 with vcount 0 -> 1; line_start exactly once per 3200 i_clk.
REQ-030 Defaults: hs low exactly for hcount 656..751, vs low exactly for vcount 490..491; active 0 at hcount 640 and at vcount 480.
REQ-031 Small config H 8/2/2/2, V 4/1/1/1, CLK_DIV 1: frame_start every 98 cycles; after 256 frames frame_cnt wraps to 0.
REQ-032 rst raised asynchronously at hcount 300, vcount 100: all outputs at reset values before next i_clk edge; after release hcount reaches 1 after 4 cycles.
REQ-033 VGA_GAME_TICK_EN defined: game_tick[0] on every 2nd, game_tick[2] on every 8th frame_start; undefined: game_tick stays 0 for 16 frames.
REQ-034 SYNC_POL 1: hs high only in window 656..751, vs high only on lines 490..491.
